// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped peripheral responder: register offsets,
// timer control bit positions and the default peripheral window base.
package periph_pkg;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGIT   = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
endpackage

// File: rtl/periph_timer.sv
// Reloadable 32-bit up-counter with overflow interrupt; owns TH, TL and TCON.
// CPU writes are applied at the same edge as the count and take priority as described below.
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we_i,
  input  logic        tl_we_i,
  input  logic        tcon_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o,
  output logic        irq_o
);
  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;
  logic        ovf_set;

  assign ovf     = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
  assign ovf_set = ovf && tcon_q[TCON_IE];

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (tcon_q[TCON_EN]) begin
      // Reload samples th_q, so a concurrent TH write only affects the next overflow.
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    tcon_d[TCON_IS] = tcon_q[TCON_IS] | ovf_set;

    if (th_we_i) th_d = wdata_i;
    if (tl_we_i) tl_d = wdata_i;
    if (tcon_we_i) begin
      tcon_d[TCON_EN] = wdata_i[TCON_EN];
      tcon_d[TCON_IE] = wdata_i[TCON_IE];
      tcon_d[TCON_IS] = wdata_i[TCON_IS] | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= 32'h0;
      tl_q   <= 32'h0;
      tcon_q <= 3'h0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IS];
endmodule

// File: rtl/periph_bus_responder.sv
// MEM-stage load/store responder: address decode, zero-latency read mux, LED/DIGIT/SYSTICK.
// Stores commit at the clock edge; loads return the pre-store value in the same cycle.
module periph_bus_responder
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          LED_W     = 8,
  parameter int          DIGIT_W   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               hit,
  output logic               irq,
  output logic [LED_W-1:0]   leds,
  output logic [DIGIT_W-1:0] digits
);
  logic [2:0]         off;
  logic               wr;
  logic [31:0]        th, tl;
  logic [2:0]         tcon;
  logic [LED_W-1:0]   led_q, led_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [31:0]        systick_q, systick_d;
  logic               unused_addr_lsbs;

  assign hit = (address[31:5] == BASE_ADDR[31:5]);
  assign off = address[4:2];
  assign wr  = MemWrite && hit;
  assign unused_addr_lsbs = ^address[1:0];

  periph_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .th_we_i   (wr && (off == OFF_TH)),
    .tl_we_i   (wr && (off == OFF_TL)),
    .tcon_we_i (wr && (off == OFF_TCON)),
    .wdata_i   (write_data),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon),
    .irq_o     (irq)
  );

  always_comb begin
    led_d     = led_q;
    digit_d   = digit_q;
    systick_d = systick_q + 32'd1;
    if (wr && (off == OFF_LED))   led_d   = write_data[LED_W-1:0];
    if (wr && (off == OFF_DIGIT)) digit_d = write_data[DIGIT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      digit_q   <= '0;
      systick_q <= 32'h0;
    end else begin
      led_q     <= led_d;
      digit_q   <= digit_d;
      systick_q <= systick_d;
    end
  end

  always_comb begin
    read_data = 32'h0;
    if (MemRead && hit) begin
      case (off)
        OFF_TH:      read_data = th;
        OFF_TL:      read_data = tl;
        OFF_TCON:    read_data = {29'h0, tcon};
        OFF_LED:     read_data = 32'(led_q);
        OFF_DIGIT:   read_data = 32'(digit_q);
        OFF_SYSTICK: read_data = systick_q;
        default:     read_data = 32'h0;
      endcase
    end
  end

  assign leds   = led_q;
  assign digits = digit_q;
endmodule

// File: tb/tb_periph_bus_responder.sv
// Scoreboard bench: the driver pushes expected outputs from a register-level model,
// a separate monitor pops and compares one entry per cycle.
module tb_periph_bus_responder;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        hit;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  periph_bus_responder #(.BASE_ADDR(BASE), .LED_W(8), .DIGIT_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .irq        (irq),
    .leds       (leds),
    .digits     (digits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        hit;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digits;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  // Reference model: one variable per architectural register.
  logic [31:0] m_th = 0, m_tl = 0, m_sys = 0;
  logic [2:0]  m_tcon = 0;
  logic [7:0]  m_led = 0;
  logic [11:0] m_digit = 0;

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return m_th;
      1: return m_tl;
      2: return {29'h0, m_tcon};
      3: return {24'h0, m_led};
      4: return {20'h0, m_digit};
      5: return m_sys;
      default: return 32'h0;
    endcase
  endfunction

  task automatic cyc(input logic rst, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic in_win;
    int   idx;
    logic wrapped;
    logic status_set;
    logic [31:0] next_tl;
    @(negedge clk);
    reset = rst; MemRead = rd; MemWrite = wr; address = a; write_data = wd;
    in_win = (a / 32) == (BASE / 32);
    idx    = int'((a % 32) / 4);
    e.hit    = in_win;
    e.rd     = (rd && in_win) ? m_read(idx) : 32'h0;
    e.irq    = m_tcon[2];
    e.leds   = m_led;
    e.digits = m_digit;
    if (chk_en) q.push_back(e);

    if (rst) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digit = 0; m_sys = 0;
    end else begin
      wrapped    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      status_set = wrapped && m_tcon[1];
      next_tl    = !m_tcon[0] ? m_tl : (wrapped ? m_th : m_tl + 1);
      m_tcon[2]  = m_tcon[2] | status_set;
      m_sys      = m_sys + 1;
      if (wr && in_win) begin
        if (idx == 0) m_th = wd;
        if (idx == 1) next_tl = wd;
        if (idx == 2) m_tcon = {wd[2] | status_set, wd[1:0]};
        if (idx == 3) m_led = wd[7:0];
        if (idx == 4) m_digit = wd[11:0];
      end
      m_tl = next_tl;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("read_data", read_data, e.rd);
        chk("hit", {31'h0, hit}, {31'h0, e.hit});
        chk("irq", {31'h0, irq}, {31'h0, e.irq});
        chk("leds", {24'h0, leds}, {24'h0, e.leds});
        chk("digits", {20'h0, digits}, {20'h0, e.digits});
      end
    end
  end

  initial begin : driver
    logic [31:0] a, wd;
    int waited;
    cyc(1, 0, 0, 32'h0, 32'h0);
    chk_en = 1'b1;
    cyc(1, 1, 0, BASE, 32'h0);

    for (int i = 0; i < 8; i++) cyc(0, 1, 0, BASE + 32'(4 * i), 32'h0);
    cyc(0, 1, 0, 32'h1000_0000, 32'h0);

    // Timer overflow with interrupt
    cyc(0, 0, 1, BASE + 0, 32'hFFFF_FFF0);
    cyc(0, 0, 1, BASE + 4, 32'hFFFF_FFFE);
    cyc(0, 0, 1, BASE + 8, 32'h3);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, BASE + 4, 32'h0);
    cyc(0, 1, 0, BASE + 8, 32'h0);

    // Clear status
    cyc(0, 1, 1, BASE + 8, 32'h3);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, BASE + ((i % 2) ? 32'd8 : 32'd4), 32'h0);

    // TCON write in the overflow cycle
    cyc(0, 0, 1, BASE + 4, 32'hFFFF_FFFE);
    cyc(0, 1, 0, BASE + 4, 32'h0);
    cyc(0, 0, 1, BASE + 8, 32'h3);
    cyc(0, 1, 0, BASE + 8, 32'h0);
    cyc(0, 0, 1, BASE + 8, 32'h3);

    // TL write in the overflow cycle
    cyc(0, 0, 1, BASE + 4, 32'hFFFF_FFFE);
    cyc(0, 1, 0, BASE + 4, 32'h0);
    cyc(0, 0, 1, BASE + 4, 32'h10);
    cyc(0, 1, 0, BASE + 4, 32'h0);
    cyc(0, 1, 0, BASE + 8, 32'h0);

    // TH write in the overflow cycle reloads the old TH
    cyc(0, 0, 1, BASE + 4, 32'hFFFF_FFFE);
    cyc(0, 1, 0, BASE + 4, 32'h0);
    cyc(0, 0, 1, BASE + 0, 32'h1234);
    cyc(0, 1, 0, BASE + 4, 32'h0);
    cyc(0, 1, 0, BASE + 0, 32'h0);

    // LED / DIGIT with simultaneous read, SYSTICK read-only
    cyc(0, 1, 1, BASE + 12, 32'hA5);
    cyc(0, 1, 1, BASE + 16, 32'h3F6);
    cyc(0, 1, 1, BASE + 20, 32'hDEAD);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, BASE + 20, 32'h0);
    cyc(0, 0, 1, BASE + 28, 32'hFFFF_FFFF);
    cyc(0, 1, 0, BASE + 12, 32'h0);

    // Reset mid-count with a pending interrupt
    cyc(0, 0, 1, BASE + 8, 32'h7);
    cyc(0, 1, 0, BASE + 8, 32'h0);
    cyc(1, 1, 0, BASE + 4, 32'h0);
    cyc(0, 1, 0, BASE + 4, 32'h0);
    cyc(0, 1, 0, BASE + 8, 32'h0);
    cyc(0, 1, 0, BASE + 20, 32'h0);

    // Random traffic biased toward timer wrap-around
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      if ($urandom_range(0, 1) == 1) wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      else wd = $urandom;
      cyc(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, a, wd);
    end

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'h0, 32'h0);
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
